// File: rtl/scheduler_pkg.sv
// Shared definitions for the timed-command scheduler: slot state encoding and
// the {time, data, addr} command word layout used by the host-side packer too.
package scheduler_pkg;

   typedef enum logic [1:0] {
      SLOT_FETCH = 2'd0,
      SLOT_WAIT  = 2'd1,
      SLOT_ARMED = 2'd2
   } slot_state_e;

   // Command word is {time, data, addr}; addr occupies the LSBs.
   function automatic int cmd_addr_lsb();
      return 0;
   endfunction

   function automatic int cmd_data_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int cmd_time_lsb(input int addr_w, input int data_w);
      return addr_w + data_w;
   endfunction

   function automatic int cmd_width(input int time_w, input int data_w, input int addr_w);
      return time_w + data_w + addr_w;
   endfunction

   function automatic int ch_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves to grant+1 whenever a grant is made.
module rr_arbiter
   import scheduler_pkg::*;
#(
   parameter  int N  = 4,
   localparam int PW = ch_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  i_req,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_grant_idx,
   output logic          o_grant_vld
);

   logic [PW-1:0] r_ptr;
   logic [PW:0]   w_sum;
   logic [PW-1:0] w_idx;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_grant_vld = 1'b0;
      w_sum       = '0;
      w_idx       = '0;
      for (int i = 0; i < N; i++) begin
         // Walk channels starting at the pointer, wrapping at N (N need not be a power of two).
         w_sum = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(N)) begin
            w_sum = w_sum - (PW+1)'(N);
         end
         w_idx = w_sum[PW-1:0];
         if (!o_grant_vld && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = w_idx;
            o_grant_vld    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (o_grant_vld) begin
         r_ptr <= (o_grant_idx == PW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/scheduler_mc.sv
// Multi-channel timed-command scheduler: per-channel prefetch slots hold one
// timestamped command until due, then a round-robin arbiter issues one bus write per cycle.
module scheduler_mc
   import scheduler_pkg::*;
#(
   parameter  int                TIME_W     = 32,
   parameter  int                DATA_W     = 32,
   parameter  int                ADDR_W     = 16,
   parameter  int                N_CH       = 4,
   parameter  logic [ADDR_W-1:0] RESET_ADDR = '1,
   parameter  int                LATE_TOL   = 0,
   localparam int                CMD_W      = cmd_width(TIME_W, DATA_W, ADDR_W),
   localparam int                CH_W       = ch_width(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TIME_W-1:0]     current_time,
   output logic                  reset_time,
   input  logic [N_CH*CMD_W-1:0] cmd_fifo_dout,
   input  logic [N_CH-1:0]       cmd_fifo_empty,
   input  logic [N_CH-1:0]       cmd_fifo_valid,
   output logic [N_CH-1:0]       cmd_fifo_rd_en,
   input  logic [N_CH-1:0]       flush,
   output logic [ADDR_W-1:0]     cmd_bus_addr,
   output logic [DATA_W-1:0]     cmd_bus_data,
   output logic                  cmd_bus_en,
   output logic                  cmd_bus_wr,
   output logic [CH_W-1:0]       cmd_bus_ch,
   output logic [15:0]           late_count,
   output logic [2*N_CH-1:0]     dbg_slot_state
);

   localparam int ADDR_LSB = cmd_addr_lsb();
   localparam int DATA_LSB = cmd_data_lsb(ADDR_W);
   localparam int TIME_LSB = cmd_time_lsb(ADDR_W, DATA_W);

   logic [N_CH-1:0]   w_req;
   logic [N_CH-1:0]   w_grant;
   logic [CH_W-1:0]   w_grant_idx;
   logic              w_grant_vld;
   logic [CMD_W-1:0]  w_slot_cmd [N_CH];
   logic [CMD_W-1:0]  w_sel_cmd;
   logic [TIME_W-1:0] w_sel_age;
   logic              w_sel_late;

   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_data;
   logic [CH_W-1:0]   r_bus_ch;
   logic              r_bus_en;
   logic              r_reset_time;
   logic [15:0]       r_late;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      slot_state_e       r_state;
      slot_state_e       w_state_nxt;
      logic [CMD_W-1:0]  r_cmd;
      logic [CMD_W-1:0]  w_dout;
      logic [TIME_W-1:0] w_age;
      logic              w_req_c;
      logic              w_rd_en_c;

      assign w_dout = cmd_fifo_dout[c*CMD_W +: CMD_W];
      // Wrap-safe: the slot is due when its timestamp lies within half the timer range behind now.
      assign w_age  = current_time - r_cmd[TIME_LSB +: TIME_W];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_state <= SLOT_FETCH;
            r_cmd   <= '0;
         end else begin
            r_state <= w_state_nxt;
            if (r_state == SLOT_WAIT && cmd_fifo_valid[c] && !flush[c]) begin
               r_cmd <= w_dout;
            end
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         if (flush[c]) begin
            w_state_nxt = SLOT_FETCH;
         end else begin
            case (r_state)
               SLOT_FETCH: if (!cmd_fifo_empty[c]) w_state_nxt = SLOT_WAIT;
               SLOT_WAIT:  w_state_nxt = cmd_fifo_valid[c] ? SLOT_ARMED : SLOT_FETCH;
               SLOT_ARMED: if (w_grant[c]) w_state_nxt = cmd_fifo_empty[c] ? SLOT_FETCH : SLOT_WAIT;
               default:    w_state_nxt = SLOT_FETCH;
            endcase
         end
      end

      always_comb begin
         w_req_c   = (r_state == SLOT_ARMED) && !w_age[TIME_W-1] && !flush[c];
         // Refill on grant so a continuously due channel issues every other cycle.
         w_rd_en_c = rst && !flush[c] && !cmd_fifo_empty[c] &&
                     ((r_state == SLOT_FETCH) || (r_state == SLOT_ARMED && w_grant[c]));
      end

      assign w_req[c]                  = w_req_c;
      assign cmd_fifo_rd_en[c]         = w_rd_en_c;
      assign w_slot_cmd[c]             = r_cmd;
      assign dbg_slot_state[2*c +: 2]  = r_state;
   end

   rr_arbiter #(
      .N (N_CH)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (w_req),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_grant_vld (w_grant_vld)
   );

   always_comb begin
      w_sel_cmd = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (w_grant[c]) begin
            w_sel_cmd = w_slot_cmd[c];
         end
      end
      w_sel_age  = current_time - w_sel_cmd[TIME_LSB +: TIME_W];
      w_sel_late = w_grant_vld && (w_sel_age > TIME_W'(LATE_TOL));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bus_addr   <= '0;
         r_bus_data   <= '0;
         r_bus_ch     <= '0;
         r_bus_en     <= 1'b0;
         r_reset_time <= 1'b0;
         r_late       <= '0;
      end else begin
         r_bus_en     <= w_grant_vld;
         r_reset_time <= w_grant_vld && (w_sel_cmd[ADDR_LSB +: ADDR_W] == RESET_ADDR);
         if (w_grant_vld) begin
            r_bus_addr <= w_sel_cmd[ADDR_LSB +: ADDR_W];
            r_bus_data <= w_sel_cmd[DATA_LSB +: DATA_W];
            r_bus_ch   <= w_grant_idx;
         end
         if (w_sel_late && r_late != 16'hFFFF) begin
            r_late <= r_late + 16'd1;
         end
      end
   end

   assign cmd_bus_addr = r_bus_addr;
   assign cmd_bus_data = r_bus_data;
   assign cmd_bus_ch   = r_bus_ch;
   assign cmd_bus_en   = r_bus_en;
   assign cmd_bus_wr   = r_bus_en;
   assign reset_time   = r_reset_time;
   assign late_count   = r_late;

endmodule

// File: tb/tb_scheduler_mc.sv
// Bench for scheduler_mc: FIFO model per channel, expected bus issues (including
// the timer value at grant) queued at stimulus time and popped as the bus strobes.
module tb_scheduler_mc;

   localparam int TW    = 32;
   localparam int DW    = 32;
   localparam int AW    = 16;
   localparam int NC    = 4;
   localparam int CW    = TW + DW + AW;
   localparam int LT    = 3;
   localparam int SB_W  = 2 + 1 + AW + DW + TW;
   localparam int DEPTH = 256;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [TW-1:0]   cur_time = '0;
   logic            reset_time;
   logic [NC*CW-1:0] fifo_dout = '0;
   logic [NC-1:0]   fifo_empty;
   logic [NC-1:0]   fifo_valid = '0;
   logic [NC-1:0]   fifo_rd_en;
   logic [NC-1:0]   flush = '0;
   logic [AW-1:0]   cmd_bus_addr;
   logic [DW-1:0]   cmd_bus_data;
   logic            cmd_bus_en;
   logic            cmd_bus_wr;
   logic [1:0]      cmd_bus_ch;
   logic [15:0]     late_count;
   logic [2*NC-1:0] dbg_slot_state;

   logic [CW-1:0]   fifo_mem [NC][DEPTH];
   int              wr_ptr [NC] = '{default: 0};
   int              rd_ptr [NC] = '{default: 0};

   logic [SB_W-1:0] exp_q [$];
   logic [15:0]     exp_late = '0;
   int              n_vec = 0;
   int              n_err = 0;
   int              bulk_issues = 0;
   logic            sb_en = 1'b1;

   scheduler_mc #(
      .TIME_W   (TW),
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .N_CH     (NC),
      .LATE_TOL (LT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .current_time   (cur_time),
      .reset_time     (reset_time),
      .cmd_fifo_dout  (fifo_dout),
      .cmd_fifo_empty (fifo_empty),
      .cmd_fifo_valid (fifo_valid),
      .cmd_fifo_rd_en (fifo_rd_en),
      .flush          (flush),
      .cmd_bus_addr   (cmd_bus_addr),
      .cmd_bus_data   (cmd_bus_data),
      .cmd_bus_en     (cmd_bus_en),
      .cmd_bus_wr     (cmd_bus_wr),
      .cmd_bus_ch     (cmd_bus_ch),
      .late_count     (late_count),
      .dbg_slot_state (dbg_slot_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- FIFO model: data valid one cycle after rd_en ----------------
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]);
      end
   end

   always @(posedge clk) begin
      for (int c = 0; c < NC; c++) begin
         fifo_valid[c] <= fifo_rd_en[c];
         if (fifo_rd_en[c]) begin
            fifo_dout[c*CW +: CW] <= fifo_mem[c][8'(rd_ptr[c])];
            rd_ptr[c]             <= rd_ptr[c] + 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_cmd(input logic [1:0] ch, input logic [TW-1:0] t,
                           input logic [DW-1:0] d, input logic [AW-1:0] a);
      fifo_mem[ch][8'(wr_ptr[ch])] = {t, d, a};
      wr_ptr[ch] = wr_ptr[ch] + 1;
   endtask

   // Expected issue: channel, reset_time, addr, data, timer value in the grant cycle.
   task automatic exp_push(input logic [1:0] ch, input logic rt, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [TW-1:0] t_grant);
      exp_q.push_back({ch, rt, a, d, t_grant});
   endtask

   // One clock: sample at negedge (scoreboard), then advance the timer after posedge.
   task automatic clk_step();
      logic [SB_W-1:0] obs;
      logic [SB_W-1:0] exp;
      @(negedge clk);
      if (cmd_bus_en === 1'b1) bulk_issues++;
      if (sb_en) begin
         n_vec++;
         if (cmd_bus_en === 1'b1) begin
            obs = {cmd_bus_ch, reset_time, cmd_bus_addr, cmd_bus_data, cur_time - 32'd1};
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_issue: got {ch,rt,addr,data,t}=%h, no issue expected", obs);
            end else begin
               exp = exp_q.pop_front();
               if (obs !== exp || cmd_bus_wr !== 1'b1) begin
                  n_err++;
                  $display("FAIL bus_issue: got {ch,rt,addr,data,t}=%h wr=%b, expected %h wr=1",
                           obs, cmd_bus_wr, exp);
               end
            end
         end else if (cmd_bus_en !== 1'b0 || cmd_bus_wr !== 1'b0 || reset_time !== 1'b0) begin
            n_err++;
            $display("FAIL idle_strobes: got en=%b wr=%b reset_time=%b, expected 0 0 0",
                     cmd_bus_en, cmd_bus_wr, reset_time);
         end
      end
      @(posedge clk);
      #1;
      cur_time = cur_time + 32'd1;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         clk_step();
         k++;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d issues outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) clk_step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({cmd_bus_en, cmd_bus_wr, reset_time} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_strobes: got %b, expected 000", {cmd_bus_en, cmd_bus_wr, reset_time});
      end
      n_vec++;
      if ({cmd_bus_ch, cmd_bus_addr, cmd_bus_data} !== '0) begin
         n_err++;
         $display("FAIL reset_bus: got ch=%h addr=%h data=%h, expected 0", cmd_bus_ch, cmd_bus_addr, cmd_bus_data);
      end
      n_vec++;
      if (late_count !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_late: got %h, expected 0000", late_count);
      end
      n_vec++;
      if (fifo_rd_en !== 4'b0000 || dbg_slot_state !== 8'h00) begin
         n_err++;
         $display("FAIL reset_slots: got rd_en=%b state=%h, expected 0000 00", fifo_rd_en, dbg_slot_state);
      end
      rst = 1'b1;
      repeat (2) clk_step();
   endtask

   task automatic test_rr_order();
      logic [DW-1:0] d;
      cur_time = 32'd40;
      for (int c = 0; c < NC; c++) begin
         d = $urandom;
         push_cmd(2'(c), 32'd50, d, AW'(16'h0100 + c));
         exp_push(2'(c), 1'b0, AW'(16'h0100 + c), d, 32'd50 + 32'(c));
      end
      drain(40);
      n_vec++;
      if (late_count !== exp_late) begin
         n_err++;
         $display("FAIL rr_late: got %h, expected %h", late_count, exp_late);
      end
   endtask

   task automatic test_single_channel();
      cur_time = 32'd90;
      push_cmd(2'd0, 32'd100, 32'hDEADBEEF, 16'h0010);
      exp_push(2'd0, 1'b0, 16'h0010, 32'hDEADBEEF, 32'd100);
      drain(40);
      n_vec++;
      if (late_count !== exp_late) begin
         n_err++;
         $display("FAIL single_late: got %h, expected %h", late_count, exp_late);
      end
   endtask

   task automatic test_rr_second_round();
      logic [DW-1:0] d;
      logic [1:0]    c;
      cur_time = 32'd200;
      for (int k = 0; k < NC; k++) begin
         c = 2'(k + 1);
         d = $urandom;
         push_cmd(c, 32'd210, d, AW'(16'h0180 + k));
         exp_push(c, 1'b0, AW'(16'h0180 + k), d, 32'd210 + 32'(k));
      end
      drain(40);
   endtask

   task automatic test_reset_addr();
      cur_time = 32'd300;
      push_cmd(2'd1, 32'd305, 32'h11112222, 16'hFFFF);
      push_cmd(2'd2, 32'd306, 32'h33334444, 16'h0020);
      exp_push(2'd1, 1'b1, 16'hFFFF, 32'h11112222, 32'd305);
      exp_push(2'd2, 1'b0, 16'h0020, 32'h33334444, 32'd306);
      drain(30);
   endtask

   task automatic test_wrap();
      logic [DW-1:0] d0, d3;
      d0 = $urandom;
      d3 = $urandom;
      cur_time = 32'hFFFF_FFF0;
      push_cmd(2'd0, 32'h0000_0002, d0, 16'h0030);
      push_cmd(2'd3, 32'h0000_0005, d3, 16'h0033);
      exp_push(2'd0, 1'b0, 16'h0030, d0, 32'h0000_0002);
      exp_push(2'd3, 1'b0, 16'h0033, d3, 32'h0000_0005);
      drain(60);
   endtask

   task automatic test_flush_armed();
      logic [DW-1:0] d;
      d = $urandom;
      cur_time = 32'd1000;
      push_cmd(2'd2, 32'd1020, 32'hBAD0BAD0, 16'h0042);
      repeat (3) clk_step();
      n_vec++;
      if (dbg_slot_state[5:4] !== 2'd2) begin
         n_err++;
         $display("FAIL flush_armed_state: got %0d, expected 2", dbg_slot_state[5:4]);
      end
      flush = 4'b0100;
      clk_step();
      flush = 4'b0000;
      push_cmd(2'd2, 32'd1040, d, 16'h0043);
      exp_push(2'd2, 1'b0, 16'h0043, d, 32'd1040);
      drain(60);
   endtask

   task automatic test_flush_wait();
      logic [DW-1:0] d;
      d = $urandom;
      cur_time = 32'd2000;
      push_cmd(2'd1, 32'd2000, 32'hBAD1BAD1, 16'h0050);
      push_cmd(2'd1, 32'd2010, d, 16'h0051);
      clk_step();
      flush = 4'b0010;
      clk_step();
      flush = 4'b0000;
      exp_push(2'd1, 1'b0, 16'h0051, d, 32'd2010);
      drain(40);
   endtask

   task automatic test_late_tolerance();
      // Age exactly LATE_TOL at grant: on time.
      cur_time = 32'd3000;
      push_cmd(2'd0, 32'd2999, 32'h0000_0A01, 16'h0060);
      exp_push(2'd0, 1'b0, 16'h0060, 32'h0000_0A01, 32'd3002);
      drain(20);
      n_vec++;
      if (late_count !== exp_late) begin
         n_err++;
         $display("FAIL late_at_tol: got %h, expected %h", late_count, exp_late);
      end
      // Age LATE_TOL+1 at grant: late.
      cur_time = 32'd3100;
      push_cmd(2'd0, 32'd3098, 32'h0000_0A02, 16'h0061);
      exp_push(2'd0, 1'b0, 16'h0061, 32'h0000_0A02, 32'd3102);
      exp_late = exp_late + 16'd1;
      drain(20);
      n_vec++;
      if (late_count !== exp_late) begin
         n_err++;
         $display("FAIL late_over_tol: got %h, expected %h", late_count, exp_late);
      end
      // Time 10 armed with the timer at 20: issued immediately, late.
      cur_time = 32'd18;
      push_cmd(2'd0, 32'd10, 32'h0000_0A03, 16'h0062);
      exp_push(2'd0, 1'b0, 16'h0062, 32'h0000_0A03, 32'd20);
      exp_late = exp_late + 16'd1;
      drain(20);
      n_vec++;
      if (late_count !== exp_late) begin
         n_err++;
         $display("FAIL late_past: got %h, expected %h", late_count, exp_late);
      end
   endtask

   task automatic test_late_saturation();
      int target;
      int sum;
      sb_en       = 1'b0;
      bulk_issues = 0;
      target      = 65535 - int'(exp_late) + 8;
      for (int k = 0; k < 70000 && bulk_issues < target; k++) begin
         for (int c = 0; c < NC; c++) begin
            if (wr_ptr[c] - rd_ptr[c] < 3) begin
               push_cmd(2'(c), cur_time - 32'd100, $urandom, 16'h0200);
            end
         end
         clk_step();
      end
      repeat (30) clk_step();
      sb_en = 1'b1;
      n_vec++;
      if (bulk_issues < target) begin
         n_err++;
         $display("FAIL sat_throughput: got %0d issues, expected at least %0d", bulk_issues, target);
      end
      sum      = int'(exp_late) + bulk_issues;
      exp_late = (sum > 65535) ? 16'hFFFF : 16'(sum);
      n_vec++;
      if (late_count !== exp_late) begin
         n_err++;
         $display("FAIL late_saturate: got %h, expected %h", late_count, exp_late);
      end
   endtask

   task automatic test_async_reset();
      cur_time = 32'd5000;
      push_cmd(2'd3, 32'd5010, 32'h5555AAAA, 16'h0070);
      repeat (3) clk_step();
      #2;
      rst = 1'b0;
      #1;
      exp_late = 16'h0000;
      n_vec++;
      if (late_count !== exp_late || dbg_slot_state !== 8'h00) begin
         n_err++;
         $display("FAIL async_reset_state: got late=%h state=%h, expected %h 00", late_count, dbg_slot_state, exp_late);
      end
      n_vec++;
      if ({cmd_bus_ch, cmd_bus_addr, cmd_bus_data} !== '0 || cmd_bus_en !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset_bus: got en=%b ch=%h addr=%h data=%h, expected 0",
                  cmd_bus_en, cmd_bus_ch, cmd_bus_addr, cmd_bus_data);
      end
      repeat (2) clk_step();
      rst = 1'b1;
      repeat (30) clk_step();
      n_vec++;
      if (late_count !== exp_late) begin
         n_err++;
         $display("FAIL async_reset_after: got late=%h, expected %h", late_count, exp_late);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_rr_order();
      test_single_channel();
      test_rr_second_round();
      test_reset_addr();
      test_wrap();
      test_flush_armed();
      test_flush_wait();
      test_late_tolerance();
      test_late_saturation();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
